// File: rtl/rc4_defs.sv
// Shared RC4 constants and the KSA state encoding.
// Used by the key-scheduling datapaths.
package rc4_defs;

  localparam int unsigned DEF_KEY_BYTES = 3;
  localparam int unsigned DEF_MEM_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    LATCH_I,
    RD_J,
    LATCH_J,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } ksa_state_t;

endpackage

// File: rtl/key_byte_sel.sv
// Supplies key[i mod KEY_BYTES]. A mod-KEY_BYTES counter tracks i,
// so no divider is needed.
module key_byte_sel #(
  parameter int unsigned KEY_BYTES = rc4_defs::DEF_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             key_byte
);

  localparam int unsigned SEL_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(KEY_BYTES - 1);

  logic [SEL_W-1:0] sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
    end else if (clear) begin
      sel <= '0;
    end else if (step) begin
      sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
    end
  end

  // key[0] is the most significant byte of secret_key.
  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (sel == SEL_W'(k)) key_byte = secret_key[(KEY_BYTES-1-k)*8 +: 8];
    end
  end

endmodule

// File: rtl/datapath_task2a.sv
// RC4 key-scheduling pass over an externally initialised S-memory.
// Seven cycles per index: read s[i], read s[j], write both, advance.
module datapath_task2a
  import rc4_defs::*;
#(
  parameter int unsigned KEY_BYTES = DEF_KEY_BYTES,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        restart,
  input  logic        commenco,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wen,
  output logic        finito
);

  localparam logic [7:0] LAST = 8'(MEM_DEPTH - 1);

  ksa_state_t state;
  logic [7:0] i, j, si, sj;
  logic [7:0] key_byte;
  logic [7:0] j_next;
  logic       start;

  assign start  = commenco && (state == IDLE || state == DONE);
  assign j_next = j + q + key_byte;

  key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk       (clk),
    .rst       (restart),
    .clear     (start),
    .step      (state == NEXT),
    .secret_key(secret_key),
    .key_byte  (key_byte)
  );

  // Outputs are registered, so each state's bus values are loaded on entry.
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      address <= '0;
      data    <= '0;
      wen     <= 1'b0;
      finito  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          address <= '0;
          data    <= '0;
          wen     <= 1'b0;
          if (commenco) begin
            i      <= '0;
            j      <= '0;
            finito <= 1'b0;
            state  <= RD_I;
          end
        end
        RD_I: state <= LATCH_I;
        LATCH_I: begin
          si      <= q;
          j       <= j_next;
          address <= j_next;
          state   <= RD_J;
        end
        RD_J: state <= LATCH_J;
        LATCH_J: begin
          sj      <= q;
          address <= i;
          data    <= q;
          wen     <= 1'b1;
          state   <= WR_I;
        end
        WR_I: begin
          address <= j;
          data    <= si;
          state   <= WR_J;
        end
        WR_J: begin
          wen   <= 1'b0;
          state <= NEXT;
        end
        NEXT: begin
          if (i == LAST) begin
            address <= '0;
            data    <= '0;
            finito  <= 1'b1;
            state   <= DONE;
          end else begin
            i       <= i + 1'b1;
            address <= i + 1'b1;
            state   <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
